cplx_mac_frame: RTL and testbench

Parametrised complex multiply-accumulate engine that succeeds the single-accumulator DSP58 complex MAC. It has the following features:
- valid-qualified input stream;
- programmable frame length, with an automatic reload and dump at each frame boundary;
- a conjugate-multiply mode;
- scaled, saturated output with an overflow flag.

It sits between sample producers (FFT/correlator front ends) and downstream detection logic, delivering one complex dot product per frame.

---
 rtl/cplx_mac_frame.sv | 182 ++++++++++++++++++
 tb/tb_cplx_mac_frame.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cplx_mac_frame.sv
// Framed complex multiply-accumulate engine: input, product, combine, accumulate and
// scale/saturate stages, delivering one saturated complex dot product per frame.
module cplx_mac_frame #(
    parameter int AW    = 18,
    parameter int BW    = 18,
    parameter int PW    = 58,
    parameter int OW    = 32,
    parameter int SHIFT = 0,
    parameter int CNTW  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   conj,
    input  logic [CNTW-1:0]        acc_len,
    input  logic signed [AW-1:0]   ar,
    input  logic signed [AW-1:0]   ai,
    input  logic signed [BW-1:0]   br,
    input  logic signed [BW-1:0]   bi,
    output logic                   out_valid,
    output logic signed [OW-1:0]   pr,
    output logic signed [OW-1:0]   pi,
    output logic                   ovf
);

    localparam int MW = AW + BW;
    localparam int SW = MW + 1;
    localparam logic signed [PW-1:0] SMAX = {{(PW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Frame position of the sample presented this cycle; r_cnt == 0 marks a frame start.
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] r_len;
    logic [CNTW-1:0] w_len;
    logic            w_first;
    logic            w_last;

    always_comb begin
        w_first = (r_cnt == '0);
        w_len   = w_first ? acc_len : r_len;
        w_last  = (r_cnt == w_len);
    end

    // NOTE: every register here, data included, is cleared by the async reset and
    // assigned with non-blocking <= so each stage reads the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_len <= '0;
        end else if (in_valid) begin
            if (w_first) r_len <= acc_len;
            r_cnt <= w_last ? '0 : r_cnt + CNTW'(1);
        end
    end

    // Stage E: input register with frame flags attached.
    logic                 r_e_valid, r_e_first, r_e_last, r_e_conj;
    logic signed [AW-1:0] r_e_ar, r_e_ai;
    logic signed [BW-1:0] r_e_br, r_e_bi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e_first <= 1'b0;
            r_e_last  <= 1'b0;
            r_e_conj  <= 1'b0;
            r_e_ar    <= '0;
            r_e_ai    <= '0;
            r_e_br    <= '0;
            r_e_bi    <= '0;
        end else begin
            r_e_valid <= in_valid;
            r_e_first <= in_valid & w_first;
            r_e_last  <= in_valid & w_last;
            r_e_conj  <= conj;
            r_e_ar    <= ar;
            r_e_ai    <= ai;
            r_e_br    <= br;
            r_e_bi    <= bi;
        end
    end

    // Stage E+1: four full-precision products.
    logic                 r_m_valid, r_m_first, r_m_last, r_m_conj;
    logic signed [MW-1:0] r_m_rr, r_m_ii, r_m_ir, r_m_ri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_first <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_conj  <= 1'b0;
            r_m_rr    <= '0;
            r_m_ii    <= '0;
            r_m_ir    <= '0;
            r_m_ri    <= '0;
        end else begin
            r_m_valid <= r_e_valid;
            r_m_first <= r_e_first;
            r_m_last  <= r_e_last;
            r_m_conj  <= r_e_conj;
            r_m_rr    <= MW'(r_e_ar) * MW'(r_e_br);
            r_m_ii    <= MW'(r_e_ai) * MW'(r_e_bi);
            r_m_ir    <= MW'(r_e_ai) * MW'(r_e_br);
            r_m_ri    <= MW'(r_e_ar) * MW'(r_e_bi);
        end
    end

    // Stage E+2: combine into real/imag; conj flips the sign of the bi terms.
    logic                 r_c_valid, r_c_first, r_c_last;
    logic signed [SW-1:0] r_c_re, r_c_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_valid <= 1'b0;
            r_c_first <= 1'b0;
            r_c_last  <= 1'b0;
            r_c_re    <= '0;
            r_c_im    <= '0;
        end else begin
            r_c_valid <= r_m_valid;
            r_c_first <= r_m_first;
            r_c_last  <= r_m_last;
            r_c_re    <= r_m_conj ? SW'(r_m_rr) + SW'(r_m_ii) : SW'(r_m_rr) - SW'(r_m_ii);
            r_c_im    <= r_m_conj ? SW'(r_m_ir) - SW'(r_m_ri) : SW'(r_m_ir) + SW'(r_m_ri);
        end
    end

    // Stage E+3: wrapping accumulator; the first sample of a frame reloads it.
    logic                 r_a_valid, r_a_last;
    logic signed [PW-1:0] r_acc_re, r_acc_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_last  <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
        end else begin
            r_a_valid <= r_c_valid;
            r_a_last  <= r_c_last;
            if (r_c_valid) begin
                r_acc_re <= r_c_first ? PW'(r_c_re) : r_acc_re + PW'(r_c_re);
                r_acc_im <= r_c_first ? PW'(r_c_im) : r_acc_im + PW'(r_c_im);
            end
        end
    end

    // Returns {clipped, value} after the arithmetic shift.
    function automatic logic [OW:0] sat(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] s;
        s = v >>> SHIFT;
        if (s > SMAX)      return {1'b1, SMAX[OW-1:0]};
        else if (s < SMIN) return {1'b1, SMIN[OW-1:0]};
        else               return {1'b0, s[OW-1:0]};
    endfunction

    logic [OW:0] w_sat_re, w_sat_im;

    always_comb begin
        w_sat_re = sat(r_acc_re);
        w_sat_im = sat(r_acc_im);
    end

    // Stage E+4: results hold between dumps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            pr        <= '0;
            pi        <= '0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= r_a_valid & r_a_last;
            if (r_a_valid && r_a_last) begin
                pr  <= w_sat_re[OW-1:0];
                pi  <= w_sat_im[OW-1:0];
                ovf <= w_sat_re[OW] | w_sat_im[OW];
            end
        end
    end

endmodule

// File: tb/tb_cplx_mac_frame.sv
// Randomized self-checking bench for cplx_mac_frame against a per-frame arithmetic
// model with a cycle-stamped scoreboard of expected dumps.
module tb_cplx_mac_frame;

    localparam int AW = 18, BW = 18, PW = 58, OW = 32, SHIFT = 0, CNTW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 conj = 1'b0;
    logic [CNTW-1:0]      acc_len = '0;
    logic signed [AW-1:0] ar = '0, ai = '0;
    logic signed [BW-1:0] br = '0, bi = '0;
    logic                 out_valid;
    logic signed [OW-1:0] pr, pi;
    logic                 ovf;

    cplx_mac_frame #(
        .AW(AW), .BW(BW), .PW(PW), .OW(OW), .SHIFT(SHIFT), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .conj(conj), .acc_len(acc_len),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(out_valid), .pr(pr), .pi(pi), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cyc;
        longint re;
        longint im;
        bit     ov;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model state: samples seen in the current frame, its length, running sums.
    int     m_cnt = 0;
    int     m_len = 0;
    longint m_re = 0, m_im = 0;

    function automatic longint wrap(input longint v);
        return (v <<< (64 - PW)) >>> (64 - PW);
    endfunction

    function automatic longint clip(input longint v);
        longint s, hi, lo;
        s  = v >>> SHIFT;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        return (s > hi) ? hi : (s < lo) ? lo : s;
    endfunction

    task automatic drive(input bit v, input bit cj, input int len,
                         input int a_r, input int a_i, input int b_r, input int b_i);
        longint re, im;
        exp_t   e;
        @(posedge clk);
        #1;
        in_valid = v;
        conj     = cj;
        acc_len  = CNTW'(len);
        ar       = AW'(a_r);
        ai       = AW'(a_i);
        br       = BW'(b_r);
        bi       = BW'(b_i);
        if (v) begin
            re = longint'(a_r) * b_r + (cj ? 1 : -1) * longint'(a_i) * b_i;
            im = longint'(a_i) * b_r + (cj ? -1 : 1) * longint'(a_r) * b_i;
            if (m_cnt == 0) begin
                m_len = len;
                m_re  = re;
                m_im  = im;
            end else begin
                m_re = wrap(m_re + re);
                m_im = wrap(m_im + im);
            end
            if (m_cnt == m_len) begin
                e.cyc = cyc + 5;
                e.re  = clip(m_re >>> 0);
                e.im  = clip(m_im);
                e.ov  = (clip(m_re) != (m_re >>> SHIFT)) || (clip(m_im) != (m_im >>> SHIFT));
                q.push_back(e);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic int rnd_op();
        return int'($urandom_range(0, (1 << AW) - 1)) - (1 << (AW - 1));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                  rnd_op(), rnd_op(), rnd_op(), rnd_op());
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_pr", longint'(pr), 0);
        check("rst_pi", longint'(pi), 0);
        check("rst_ovf", longint'(ovf), 0);
        q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Every cycle where a dump is either seen or due is compared against the scoreboard.
    always @(negedge clk) begin
        bit exp_v;
        if (rst_n) begin
            exp_v = (q.size() > 0) && (q[0].cyc == cyc);
            if (out_valid || exp_v) check("out_valid", longint'(out_valid), longint'(exp_v));
            if (exp_v) begin
                check("pr", longint'(pr), q[0].re);
                check("pi", longint'(pi), q[0].im);
                check("ovf", longint'(ovf), longint'(q[0].ov));
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2;
        check("init_pr", longint'(pr), 0);
        check("init_out_valid", longint'(out_valid), 0);
        #10;
        rst_n = 1'b1;

        drive(1, 0, 0, 3, 4, 1, 2);
        idle(6);
        drive(1, 1, 0, 3, 4, 1, 2);
        idle(6);

        for (int i = 0; i < 4; i++) drive(1, 0, 3, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) drive(1, 0, 3, 2, 0, 3, 0);
        idle(6);

        drive(1, 0, 1, 5, -2, 7, 3);
        idle(3);
        drive(1, 0, 1, -4, 6, 2, -9);
        drive(1, 0, 1, 5, -2, 7, 3);
        drive(1, 0, 1, -4, 6, 2, -9);
        idle(6);

        for (int i = 0; i < 8; i++)
            drive(1, 1'($urandom_range(0, 1)), 0, rnd_op(), rnd_op(), rnd_op(), rnd_op());
        idle(6);

        drive(1, 0, 0, -131072, 0, -131072, 0);
        idle(6);
        drive(1, 0, 0, 7, -3, 2, 5);
        idle(6);

        drive(1, 0, 3, 9, 9, 9, 9);
        drive(1, 0, 3, 9, 9, 9, 9);
        pulse_reset();
        for (int i = 0; i < 4; i++) drive(1, 0, 3, 1, 0, 1, 0);
        idle(6);

        // Random frames: random lengths (changed mid-frame), gaps and full-range operands.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7)
                drive(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                      rnd_op(), rnd_op(), rnd_op(), rnd_op());
            else
                idle(1);
        end
        // Close any open frame with length-0 requests, which are ignored mid-frame.
        while (m_cnt != 0) drive(1, 0, 0, 1, 2, 3, 4);

        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        check("drain", longint'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
